// File: rtl/irq_pending_latch_if.sv
// irq_pending_latch_if: request/mask/ack bundle between interrupt source logic and the pending latch
interface irq_pending_latch_if;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_din;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;
  logic [7:0] req_vec;
  logic       any_pend;
  logic [7:0] pend_raw;
  logic [7:0] ovf;
  logic       ack_err;
  modport master (
    output irq_in, mask_we, mask_din, ack, ack_idx, ovf_clr,
    input  req_vec, any_pend, pend_raw, ovf, ack_err
  );
  modport slave (
    input  irq_in, mask_we, mask_din, ack, ack_idx, ovf_clr,
    output req_vec, any_pend, pend_raw, ovf, ack_err
  );
endinterface

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky interrupt pending bits with mask, indexed ack clear and overflow tracking
module irq_pending_latch #(
  parameter bit         EDGE     = 1'b1,
  parameter logic [7:0] MASK_RST = 8'h00
) (
  input logic            clk,
  input logic            rst,
  irq_pending_latch_if.slave bus
);
  logic [7:0] irq_q, irq_d, pend_q, pend_d, mask_q, mask_d, ovf_q, ovf_d, evt, clr;
  logic       ack_err_q, ack_err_d;
  // next-state: events set pending (winning over a same-cycle ack), lost events raise overflow
  always_comb begin
    evt       = EDGE ? (bus.irq_in & ~irq_q) : bus.irq_in;
    clr       = bus.ack ? (8'd1 << bus.ack_idx) : 8'd0;
    irq_d     = bus.irq_in;
    pend_d    = evt | (pend_q & ~clr);
    ovf_d     = (bus.ovf_clr ? 8'd0 : ovf_q) | (evt & pend_q & ~clr);
    mask_d    = bus.mask_we ? bus.mask_din : mask_q;
    ack_err_d = bus.ack & ~pend_q[bus.ack_idx];
  end
  // state update; irq_q keeps sampling in reset so a line held high through reset is not an edge
  always_ff @(posedge clk) begin
    irq_q <= irq_d;
    if (rst) begin
      pend_q    <= 8'h00;
      ovf_q     <= 8'h00;
      mask_q    <= MASK_RST;
      ack_err_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
      ack_err_q <= ack_err_d;
    end
  end
  assign bus.req_vec  = pend_q & ~mask_q;
  assign bus.any_pend = |bus.req_vec;
  assign bus.pend_raw = pend_q;
  assign bus.ovf      = ovf_q;
  assign bus.ack_err  = ack_err_q;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed checks of edge and level capture, masking, ack, overflow and reset
module tb_irq_pending_latch;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  irq_pending_latch_if b1 ();
  irq_pending_latch_if b0 ();
  irq_pending_latch #(.EDGE(1'b1), .MASK_RST(8'h00)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  irq_pending_latch #(.EDGE(1'b0), .MASK_RST(8'h00)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    b1.irq_in = 8'h81; b1.mask_we = 0; b1.mask_din = 0; b1.ack = 0; b1.ack_idx = 0; b1.ovf_clr = 0;
    b0.irq_in = 8'h00; b0.mask_we = 0; b0.mask_din = 0; b0.ack = 0; b0.ack_idx = 0; b0.ovf_clr = 0;
    tick(); tick();
    chk("rst_pend", b1.pend_raw, 8'h00);
    chk("rst_req", b1.req_vec, 8'h00);
    chk("rst_any", {7'd0, b1.any_pend}, 8'h00);
    chk("rst_ovf", b1.ovf, 8'h00);
    chk("rst_err", {7'd0, b1.ack_err}, 8'h00);
    rst = 1'b0;
    tick();
    chk("held_pend", b1.pend_raw, 8'h00);
    tick();
    chk("held_any", {7'd0, b1.any_pend}, 8'h00);
    b1.irq_in = 8'h80; tick();
    chk("drop0_pend", b1.pend_raw, 8'h00);
    b1.irq_in = 8'h81; tick();
    chk("rise0_pend", b1.pend_raw, 8'h01);
    chk("rise0_req", b1.req_vec, 8'h01);
    b1.irq_in = 8'h00; b1.ack = 1; b1.ack_idx = 0; tick(); b1.ack = 0;
    chk("ack0_pend", b1.pend_raw, 8'h00);
    b1.irq_in = 8'h44; tick();
    chk("edge26_req", b1.req_vec, 8'h44);
    b1.ack = 1; b1.ack_idx = 6; tick();
    chk("ack6_req", b1.req_vec, 8'h04);
    chk("ack6_err", {7'd0, b1.ack_err}, 8'h00);
    b1.ack_idx = 2; tick(); b1.ack = 0;
    chk("ack2_any", {7'd0, b1.any_pend}, 8'h00);
    chk("ack2_req", b1.req_vec, 8'h00);
    b1.irq_in = 8'h00; b1.mask_we = 1; b1.mask_din = 8'h40; tick(); b1.mask_we = 0;
    b1.irq_in = 8'h40; tick();
    chk("masked_pend", b1.pend_raw, 8'h40);
    chk("masked_req", b1.req_vec, 8'h00);
    chk("masked_any", {7'd0, b1.any_pend}, 8'h00);
    b1.irq_in = 8'h00; b1.mask_we = 1; b1.mask_din = 8'h00; tick();
    chk("unmask_req", b1.req_vec, 8'h40);
    b1.mask_din = 8'h40; tick(); b1.mask_we = 0;
    chk("remask_req", b1.req_vec, 8'h00);
    b1.ack = 1; b1.ack_idx = 6; tick(); b1.ack = 0;
    chk("ackmasked_pend", b1.pend_raw, 8'h00);
    chk("ackmasked_err", {7'd0, b1.ack_err}, 8'h00);
    b1.mask_we = 1; b1.mask_din = 8'h00; tick(); b1.mask_we = 0;
    b1.irq_in = 8'h08; tick();
    chk("p3_pend", b1.pend_raw, 8'h08);
    b1.irq_in = 8'h00; tick();
    b1.irq_in = 8'h08; tick();
    chk("ovf3", b1.ovf, 8'h08);
    chk("ovf3_pend", b1.pend_raw, 8'h08);
    b1.irq_in = 8'h00; b1.ovf_clr = 1; tick(); b1.ovf_clr = 0;
    chk("ovfclr", b1.ovf, 8'h00);
    b1.irq_in = 8'h08; b1.ack = 1; b1.ack_idx = 3; tick(); b1.ack = 0;
    chk("setwin_pend", b1.pend_raw, 8'h08);
    chk("setwin_ovf", b1.ovf, 8'h00);
    b1.irq_in = 8'h00; tick();
    b1.irq_in = 8'h08; b1.ovf_clr = 1; tick();
    chk("ovfclr_setwin", b1.ovf, 8'h08);
    b1.irq_in = 8'h00; b1.ack = 1; b1.ack_idx = 3; tick(); b1.ack = 0; b1.ovf_clr = 0;
    chk("clr3_pend", b1.pend_raw, 8'h00);
    chk("clr3_ovf", b1.ovf, 8'h00);
    b1.ack = 1; b1.ack_idx = 5; tick(); b1.ack = 0;
    chk("err5_hi", {7'd0, b1.ack_err}, 8'h01);
    chk("err5_pend", b1.pend_raw, 8'h00);
    tick();
    chk("err5_lo", {7'd0, b1.ack_err}, 8'h00);
    b1.irq_in = 8'h20; tick();
    b1.irq_in = 8'h00; b1.ack = 1; b1.ack_idx = 5; tick(); b1.ack = 0;
    chk("ok5_err", {7'd0, b1.ack_err}, 8'h00);
    chk("ok5_pend", b1.pend_raw, 8'h00);
    b1.irq_in = 8'h03; tick(); b1.irq_in = 8'h00;
    chk("b2b_pend", b1.pend_raw, 8'h03);
    b1.ack = 1; b1.ack_idx = 0; tick();
    chk("b2b_ack0", b1.pend_raw, 8'h02);
    b1.ack_idx = 1; tick(); b1.ack = 0;
    chk("b2b_ack1", b1.pend_raw, 8'h00);
    b1.irq_in = 8'h10; tick(); b1.irq_in = 8'h00;
    chk("p4_pend", b1.pend_raw, 8'h10);
    rst = 1; b1.ack = 1; b1.ack_idx = 5; tick(); rst = 0; b1.ack = 0;
    chk("rstmid_pend", b1.pend_raw, 8'h00);
    chk("rstmid_err", {7'd0, b1.ack_err}, 8'h00);
    b0.irq_in = 8'h02; b0.ack = 1; b0.ack_idx = 1;
    tick();
    chk("lvl_pend_a", b0.pend_raw, 8'h02);
    tick();
    chk("lvl_pend_b", b0.pend_raw, 8'h02);
    chk("lvl_ovf_b", b0.ovf, 8'h00);
    tick();
    chk("lvl_pend_c", b0.pend_raw, 8'h02);
    chk("lvl_ovf_c", b0.ovf, 8'h00);
    b0.ack = 0; tick();
    chk("lvl_ovf_noack", b0.ovf, 8'h02);
    rst = 1; tick(); rst = 0; b0.irq_in = 8'h00;
    chk("lvl_rst_pend", b0.pend_raw, 8'h00);
    chk("lvl_rst_ovf", b0.ovf, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
